// File: rtl/controle_desvio_pkg.sv
// Shared definitions for the nRISC fetch/execute sequencer and branch resolver.
package controle_desvio_pkg;

    localparam int PC_W_DEF     = 8;
    localparam int RESET_PC_DEF = 0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        EXEC  = ST_EXEC,
        HALT  = ST_HALT
    } estado_t;

endpackage

// File: rtl/controle_desvio_calc_prox_pc.sv
// Combinational branch resolution: next PC plus the taken / consume / halt decisions.
module calc_prox_pc #(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0] pc,
    input  logic            op_halt,
    input  logic            op_jmp,
    input  logic            op_brc,
    input  logic            cond_atual,
    input  logic [PC_W-1:0] tgt_addr,
    output logic [PC_W-1:0] prox_pc,
    output logic            taken,
    output logic            consume,
    output logic            halt
);

    always_comb begin
        prox_pc = pc + PC_W'(1);
        taken   = 1'b0;
        consume = 1'b0;
        halt    = 1'b0;
        if (op_halt) begin
            prox_pc = pc;
            halt    = 1'b1;
        end else if (op_jmp) begin
            prox_pc = tgt_addr;
            taken   = 1'b1;
        end else if (op_brc) begin
            // The flag is consumed by any conditional branch, taken or not.
            consume = 1'b1;
            if (cond_atual) begin
                prox_pc = tgt_addr;
                taken   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/controle_desvio.sv
// nRISC fetch/execute sequencer: owns the PC, drives instruction fetch and
// resolves jumps/branches against the COND flag.
module controle_desvio
    import controle_desvio_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            imem_ack,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            op_halt,
    input  logic            op_jmp,
    input  logic            op_brc,
    input  logic [PC_W-1:0] tgt_addr,
    input  logic            cond_atual,
    output logic            exec_en,
    output logic            reset_cond,
    output logic            branch_taken,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    estado_t         estado;
    estado_t         prox_estado;
    logic [PC_W-1:0] prox_pc;
    logic            taken;
    logic            consume;
    logic            halt;

    calc_prox_pc #(.PC_W(PC_W)) u_calc (
        .pc         (pc),
        .op_halt    (op_halt),
        .op_jmp     (op_jmp),
        .op_brc     (op_brc),
        .cond_atual (cond_atual),
        .tgt_addr   (tgt_addr),
        .prox_pc    (prox_pc),
        .taken      (taken),
        .consume    (consume),
        .halt       (halt)
    );

    always_comb begin
        prox_estado = estado;
        case (estado)
            IDLE:    prox_estado = FETCH;
            FETCH:   if (imem_ack) prox_estado = EXEC;
            EXEC:    prox_estado = halt ? HALT : FETCH;
            HALT:    prox_estado = HALT;
            default: prox_estado = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado <= IDLE;
            pc     <= RESET_PC;
        end else begin
            estado <= prox_estado;
            // PC only moves on the edge leaving EXEC.
            if (estado == EXEC) pc <= prox_pc;
        end
    end

    // Strobes decode from state, so the async reset clears them immediately.
    assign imem_req     = (estado == FETCH);
    assign imem_addr    = pc;
    assign exec_en      = (estado == EXEC);
    assign branch_taken = exec_en & taken;
    assign reset_cond   = exec_en & consume;
    assign halted       = (estado == HALT);

endmodule
